// File: rtl/riscv32_fetch_queue_if.sv
// Fetch front-end bus: kickoff control, I-cache port, redirect port,
// instruction pop handshake and status taps.
interface riscv32_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              icache_go;
  logic [ADDR_W-1:0] pc_kickoff_addr;
  logic              i_cache_rden;
  logic [ADDR_W-1:0] i_cache_rdaddr;
  logic              i_cache_rdhit;
  logic [31:0]       i_cache_rddata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  stat_miss_cnt;

  // Fetch unit side
  modport master (
    input  icache_go, pc_kickoff_addr, i_cache_rdhit, i_cache_rddata,
           redirect_valid, redirect_addr, instr_ready,
    output i_cache_rden, i_cache_rdaddr, instr_valid, instr, instr_pc,
           fetch_pc, stat_miss_cnt
  );

  // Cache / pipeline side
  modport slave (
    output icache_go, pc_kickoff_addr, i_cache_rdhit, i_cache_rddata,
           redirect_valid, redirect_addr, instr_ready,
    input  i_cache_rden, i_cache_rdaddr, instr_valid, instr, instr_pc,
           fetch_pc, stat_miss_cnt
  );
endinterface

// File: rtl/riscv32_fetch_queue.sv
// Instruction fetch front end: kickoff FSM, I-cache request generator and a
// DEPTH-entry {pc, instr} prefetch queue popped with valid/ready.
module riscv32_fetch_queue #(
  parameter int          ADDR_W    = 32,
  parameter int          DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  riscv32_fetch_queue_if.master fq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              go_d1, rise;
  logic              rden, push, pop, flush;
  logic [ADDR_W-1:0] fetch_pc, pc_nxt, rdaddr;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [31:0]       ins_q [DEPTH];
  logic [CNT_W-1:0]  miss_cnt;
  logic              valid;

  assign rise   = fq.icache_go & ~go_d1;
  assign rdaddr = {fetch_pc[ADDR_W-1:2], 2'b00};
  assign valid  = (count != '0);
  // A full queue blocks the request even if the head is being popped.
  assign rden   = (state == RUN) & fq.icache_go & (count < FULL) & ~fq.redirect_valid;

  // State, fetch PC and go edge detector
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      go_d1    <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= pc_nxt;
      go_d1    <= fq.icache_go;
    end
  end

  // Next state and queue control; rise beats go-drop beats redirect beats fetch
  always_comb begin
    state_nxt = state;
    pc_nxt    = fetch_pc;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = RUN;
          pc_nxt    = fq.pc_kickoff_addr;
        end
      end
      RUN: begin
        if (rise) begin
          flush  = 1'b1;
          pc_nxt = fq.pc_kickoff_addr;
        end else if (!fq.icache_go) begin
          state_nxt = IDLE;
          flush     = 1'b1;
        end else if (fq.redirect_valid) begin
          // Low PC bits are kept here and dropped on the next request.
          flush  = 1'b1;
          pc_nxt = fq.redirect_addr;
        end else begin
          push = rden & fq.i_cache_rdhit;
          pop  = valid & fq.instr_ready;
          if (push) pc_nxt = fetch_pc + ADDR_W'(4);
        end
      end
    endcase
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Queue storage; contents are don't-care until the pointer says otherwise
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]  <= rdaddr;
      ins_q[wr_ptr] <= fq.i_cache_rddata;
    end
  end

  // Saturating miss-cycle counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                     miss_cnt <= '0;
    else if (rden && !fq.i_cache_rdhit && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
  end

  assign fq.i_cache_rden   = rden;
  assign fq.i_cache_rdaddr = rdaddr;
  assign fq.instr_valid    = valid;
  assign fq.instr          = valid ? ins_q[rd_ptr] : NOP_INSTR;
  assign fq.instr_pc       = valid ? pc_q[rd_ptr] : '0;
  assign fq.fetch_pc       = fetch_pc;
  assign fq.stat_miss_cnt  = miss_cnt;
endmodule

// File: tb/tb_riscv32_fetch_queue.sv
// Directed bench for riscv32_fetch_queue with a pop scoreboard.
module tb_riscv32_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  riscv32_fetch_queue_if #(.ADDR_W(32), .CNT_W(32)) fq();

  riscv32_fetch_queue #(
    .ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(32)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .fq   (fq)
  );

  // I-cache contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign fq.i_cache_rddata = mem_f(fq.i_cache_rdaddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold ready until the scoreboard has drained, bounded
  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    fq.instr_ready = 1'b0;
    chk(tag, sb.size(), 0);
    sb.delete();
  endtask

  // Every accepted pop must match the oldest expected entry
  always @(negedge clk) begin
    if (rstn && fq.icache_go && !fq.redirect_valid && fq.instr_valid && fq.instr_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL extra_pop: observed pop of %08h expected none", fq.instr_pc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("pop_pc", fq.instr_pc, e);
        chk("pop_instr", fq.instr, mem_f(e));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    fq.icache_go = 1'b0;
    fq.pc_kickoff_addr = '0;
    fq.i_cache_rdhit = 1'b1;
    fq.redirect_valid = 1'b0;
    fq.redirect_addr = '0;
    fq.instr_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rden", fq.i_cache_rden, 0);
    chk("rst_valid", fq.instr_valid, 0);
    chk("rst_instr", fq.instr, NOP);
    chk("rst_pc", fq.instr_pc, 0);
    chk("rst_fetch_pc", fq.fetch_pc, 0);
    chk("rst_miss", fq.stat_miss_cnt, 0);
    step();
    rstn = 1'b1;
    step();

    // Kickoff at 0x100 and stream with ready=1
    fq.pc_kickoff_addr = 32'h100;
    fq.icache_go = 1'b1;
    step();
    fq.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(32'h100 + 32'(i * 4));
    @(negedge clk);
    chk("kick_rden", fq.i_cache_rden, 1);
    chk("kick_rdaddr", fq.i_cache_rdaddr, 32'h100);
    chk("kick_fetch_pc", fq.fetch_pc, 32'h100);
    chk("kick_valid", fq.instr_valid, 0);
    step();
    @(negedge clk);
    chk("stream_fetch_pc", fq.fetch_pc, 32'h104);
    chk("stream_valid", fq.instr_valid, 1);
    drain("stream_drain");

    // Drop go for two cycles: back to IDLE with an empty queue
    fq.icache_go = 1'b0;
    @(negedge clk);
    chk("drop_rden", fq.i_cache_rden, 0);
    step();
    @(negedge clk);
    chk("drop_valid", fq.instr_valid, 0);
    chk("drop_instr", fq.instr, NOP);
    chk("drop_pc", fq.instr_pc, 0);
    step();

    // Re-kick at 0x200 with a simultaneous (ignored) redirect; ready=0
    fq.pc_kickoff_addr = 32'h200;
    fq.icache_go = 1'b1;
    fq.redirect_valid = 1'b1;
    fq.redirect_addr = 32'h3000;
    @(negedge clk);
    chk("rekick_rden_idle", fq.i_cache_rden, 0);
    step();
    fq.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rekick_fetch_pc", fq.fetch_pc, 32'h200);
    chk("rekick_rden", fq.i_cache_rden, 1);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("full_rden", fq.i_cache_rden, 0);
    chk("full_rdaddr", fq.i_cache_rdaddr, 32'h210);
    chk("full_head", fq.instr_pc, 32'h200);
    step();
    @(negedge clk);
    chk("full_head_stable", fq.instr_pc, 32'h200);
    chk("full_instr_stable", fq.instr, mem_f(32'h200));
    step();
    for (int i = 0; i < 5; i++) sb.push_back(32'h200 + 32'(i * 4));
    fq.instr_ready = 1'b1;
    drain("backpressure_drain");

    // Redirect to 0x2002 with a non-empty queue and ready=1
    fq.redirect_valid = 1'b1;
    fq.redirect_addr = 32'h2002;
    fq.instr_ready = 1'b1;
    @(negedge clk);
    chk("redir_rden", fq.i_cache_rden, 0);
    chk("redir_valid_before", fq.instr_valid, 1);
    step();
    fq.redirect_valid = 1'b0;
    sb.push_back(32'h2000);
    sb.push_back(32'h2004);
    @(negedge clk);
    chk("redir_valid_after", fq.instr_valid, 0);
    chk("redir_instr_nop", fq.instr, NOP);
    chk("redir_pc_zero", fq.instr_pc, 0);
    chk("redir_rdaddr", fq.i_cache_rdaddr, 32'h2000);
    chk("redir_fetch_pc", fq.fetch_pc, 32'h2002);
    chk("redir_rden_next", fq.i_cache_rden, 1);

    // Three miss cycles at 0x2004, then a hit
    step();
    fq.i_cache_rdhit = 1'b0;
    @(negedge clk);
    chk("miss1_rdaddr", fq.i_cache_rdaddr, 32'h2004);
    step();
    @(negedge clk);
    chk("miss2_rdaddr", fq.i_cache_rdaddr, 32'h2004);
    chk("miss2_valid", fq.instr_valid, 0);
    step();
    @(negedge clk);
    chk("miss3_rdaddr", fq.i_cache_rdaddr, 32'h2004);
    chk("miss3_valid", fq.instr_valid, 0);
    step();
    fq.i_cache_rdhit = 1'b1;
    @(negedge clk);
    chk("miss_cnt", fq.stat_miss_cnt, 3);
    chk("miss_hit_rdaddr", fq.i_cache_rdaddr, 32'h2004);
    drain("miss_drain");

    // Go drop then kickoff near the top of the address space
    fq.icache_go = 1'b0;
    step();
    step();
    fq.pc_kickoff_addr = 32'hFFFF_FFF8;
    fq.icache_go = 1'b1;
    fq.redirect_valid = 1'b1;
    fq.redirect_addr = 32'h5000;
    step();
    fq.redirect_valid = 1'b0;
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    sb.push_back(32'h0000_0004);
    fq.instr_ready = 1'b1;
    @(negedge clk);
    chk("wrap_fetch_pc", fq.fetch_pc, 32'hFFFF_FFF8);
    drain("wrap_drain");

    // Asynchronous reset mid-stream
    #2;
    rstn = 1'b0;
    #1;
    chk("areset_rden", fq.i_cache_rden, 0);
    chk("areset_valid", fq.instr_valid, 0);
    chk("areset_instr", fq.instr, NOP);
    chk("areset_fetch_pc", fq.fetch_pc, 0);
    chk("areset_miss", fq.stat_miss_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
